// File: rtl/window_line_buffer.sv
// KxK sliding-window generator: K-1 line memories feed a KxK register window
// from a raster pixel stream, with valid qualification, optional stride-2
// decimation, window position outputs and row-length configuration checking.
module window_line_buffer #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned K       = 3,
  parameter int unsigned MAX_ROW = 256,
  parameter int unsigned ADDR_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  input  logic [ADDR_W-1:0]         row_length,
  input  logic                      stride2,
  output logic                      win_valid,
  output logic [K*K*DATA_W-1:0]     win_data,
  output logic [ADDR_W-1:0]         win_row,
  output logic [ADDR_W-1:0]         win_col,
  output logic                      cfg_err
);

  localparam int unsigned NMEM  = K - 1;
  localparam int unsigned WIN_W = K * K * DATA_W;
  localparam logic [ADDR_W-1:0] ROW_MAX = '1;
  localparam logic [ADDR_W-1:0] KM1     = ADDR_W'(K - 1);

  logic [ADDR_W-1:0] col_q, col_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] cfg_len_q, cfg_len_d;
  logic              cfg_s2_q, cfg_s2_d;
  logic              cfg_err_q, cfg_err_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic              win_valid_q, win_valid_d;
  logic [ADDR_W-1:0] win_row_q, win_row_d;
  logic [ADDR_W-1:0] win_col_q, win_col_d;

  logic [DATA_W-1:0] mem_q  [NMEM][MAX_ROW];
  logic [DATA_W-1:0] mem_rd [NMEM];
  logic [DATA_W-1:0] mem_wd [NMEM];

  logic idle;
  logic cfg_bad;
  logic accept;
  logic last_col;
  logic on_grid;

  // Row length must cover the kernel and fit the line memories.
  function automatic logic cfg_illegal(input logic [ADDR_W-1:0] len);
    return (32'(len) < K) || (32'(len) > MAX_ROW);
  endfunction

  // Beat qualification and position decode.
  always_comb begin : ctrl_decode
    idle     = (col_q == '0) && (row_q == '0);
    cfg_bad  = cfg_illegal(cfg_len_q);
    accept   = in_valid && !cfg_bad && !clear;
    last_col = (col_q == cfg_len_q - ADDR_W'(1));
    // K-1 is even, so the parity of (pos-K+1) equals the parity of pos.
    on_grid  = !cfg_s2_q || (!row_q[0] && !col_q[0]);
  end

  // Combinational line-memory reads and the write-data cascade (read-before-write).
  always_comb begin : line_mem_path
    for (int unsigned i = 0; i < NMEM; i++) begin
      mem_rd[i] = mem_q[i][col_q];
    end
    mem_wd[0] = in_data;
    for (int unsigned i = 1; i < NMEM; i++) begin
      mem_wd[i] = mem_rd[i-1];
    end
  end

  // Window shift: every row moves one column left, new column enters at c=K-1.
  always_comb begin : window_next
    win_d = win_q;
    if (accept) begin
      for (int unsigned r = 0; r < K; r++) begin
        for (int unsigned c = 0; c < K; c++) begin
          if (c < K - 1) begin
            win_d[(r*K+c)*DATA_W +: DATA_W] = win_q[(r*K+c+1)*DATA_W +: DATA_W];
          end else if (r == K - 1) begin
            win_d[(r*K+c)*DATA_W +: DATA_W] = in_data;
          end else begin
            win_d[(r*K+c)*DATA_W +: DATA_W] = mem_rd[K-2-r];
          end
        end
      end
    end
  end

  // Column/row counters, configuration latch and window qualification.
  always_comb begin : counters_next
    col_d       = col_q;
    row_d       = row_q;
    cfg_len_d   = cfg_len_q;
    cfg_s2_d    = cfg_s2_q;
    win_valid_d = 1'b0;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;

    if (idle) begin
      cfg_len_d = row_length;
      cfg_s2_d  = stride2;
    end

    if (clear) begin
      col_d     = '0;
      row_d     = '0;
      win_row_d = '0;
      win_col_d = '0;
    end else if (accept) begin
      win_row_d   = row_q;
      win_col_d   = col_q;
      win_valid_d = (row_q >= KM1) && (col_q >= KM1) && on_grid;
      if (last_col) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? row_q : row_q + ADDR_W'(1);
      end else begin
        col_d = col_q + ADDR_W'(1);
      end
    end

    cfg_err_d = cfg_illegal(cfg_len_d);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin : state_regs
    if (!rst) begin
      col_q       <= '0;
      row_q       <= '0;
      cfg_len_q   <= '0;
      cfg_s2_q    <= 1'b0;
      cfg_err_q   <= 1'b0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      cfg_len_q   <= cfg_len_d;
      cfg_s2_q    <= cfg_s2_d;
      cfg_err_q   <= cfg_err_d;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
    end
  end

  // Line memories; contents are don't-care until overwritten, so no reset.
  always_ff @(posedge clk) begin : line_mem_write
    if (accept) begin
      for (int unsigned i = 0; i < NMEM; i++) begin
        mem_q[i][col_q] <= mem_wd[i];
      end
    end
  end

  assign win_valid = win_valid_q;
  assign win_data  = win_q;
  assign win_row   = win_row_q;
  assign win_col   = win_col_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_window_line_buffer.sv
// Bench for window_line_buffer: random stimulus checked cycle by cycle against
// an image-array reference model, plus the directed frame scenarios.
module tb_window_line_buffer;

  localparam int DATA_W  = 16;
  localparam int K       = 3;
  localparam int MAX_ROW = 256;
  localparam int ADDR_W  = 8;
  localparam int WIN_W   = K * K * DATA_W;

  logic               clk = 1'b0;
  logic               rst;
  logic               clear;
  logic               in_valid;
  logic [DATA_W-1:0]  in_data;
  logic [ADDR_W-1:0]  row_length;
  logic               stride2;
  logic               win_valid;
  logic [WIN_W-1:0]   win_data;
  logic [ADDR_W-1:0]  win_row;
  logic [ADDR_W-1:0]  win_col;
  logic               cfg_err;

  window_line_buffer #(
    .DATA_W(DATA_W), .K(K), .MAX_ROW(MAX_ROW), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .row_length(row_length), .stride2(stride2), .win_valid(win_valid),
    .win_data(win_data), .win_row(win_row), .win_col(win_col), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the image as a 2-D array plus frame position and cfg.
  logic [DATA_W-1:0] img [256][256];
  int m_col, m_row, m_len;
  bit m_s2;
  bit e_valid, e_err;
  int e_row, e_col;
  logic [WIN_W-1:0] e_win;

  // Observed valid windows of the current scenario.
  logic [WIN_W-1:0] q_win [$];
  logic [WIN_W-1:0] t1_win [$];
  int q_row [$];
  int q_col [$];

  task automatic check_eq(input string tag, input logic [WIN_W-1:0] got, input logic [WIN_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit cfg_bad(input int len);
    return (len < K) || (len > MAX_ROW);
  endfunction

  function automatic logic [WIN_W-1:0] pack9(input int v0, v1, v2, v3, v4, v5, v6, v7, v8);
    logic [WIN_W-1:0] w;
    int v [9];
    v = '{v0, v1, v2, v3, v4, v5, v6, v7, v8};
    for (int i = 0; i < 9; i++) w[i*DATA_W +: DATA_W] = DATA_W'(v[i]);
    return w;
  endfunction

  task automatic model_reset();
    m_col = 0; m_row = 0; m_len = 0; m_s2 = 0;
    e_valid = 0; e_err = 0; e_row = 0; e_col = 0;
  endtask

  task automatic clear_capture();
    q_win.delete(); q_row.delete(); q_col.delete();
  endtask

  // One clock: drive inputs, advance the model, compare all outputs.
  task automatic cycle(input bit v, input logic [DATA_W-1:0] d, input bit clr);
    bit idle, acc;
    in_valid = v; in_data = d; clear = clr;
    @(posedge clk); #1;
    idle = (m_col == 0) && (m_row == 0);
    acc  = v && !cfg_bad(m_len) && !clr;
    e_valid = 0;
    if (clr) begin
      m_col = 0; m_row = 0; e_row = 0; e_col = 0;
    end else if (acc) begin
      img[m_row][m_col] = d;
      e_row = m_row; e_col = m_col;
      e_valid = (m_row >= K-1) && (m_col >= K-1) &&
                (!m_s2 || (((m_row-(K-1)) % 2 == 0) && ((m_col-(K-1)) % 2 == 0)));
      if (e_valid)
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++)
            e_win[(r*K+c)*DATA_W +: DATA_W] = img[m_row-(K-1)+r][m_col-(K-1)+c];
      m_col++;
      if (m_col == m_len) begin
        m_col = 0;
        if (m_row < 255) m_row++;
      end
    end
    if (idle) begin
      m_len = int'(row_length); m_s2 = stride2;
    end
    e_err = cfg_bad(m_len);

    check_eq("win_valid", WIN_W'(win_valid), WIN_W'(e_valid));
    check_eq("cfg_err", WIN_W'(cfg_err), WIN_W'(e_err));
    check_eq("win_row", WIN_W'(win_row), WIN_W'(e_row));
    check_eq("win_col", WIN_W'(win_col), WIN_W'(e_col));
    if (e_valid) check_eq("win_data", win_data, e_win);
    if (win_valid) begin
      q_win.push_back(win_data); q_row.push_back(int'(win_row)); q_col.push_back(int'(win_col));
    end
  endtask

  task automatic restart(input int len, input bit s2);
    row_length = ADDR_W'(len); stride2 = s2;
    cycle(0, '0, 1);
    cycle(0, '0, 0);
    clear_capture();
  endtask

  task automatic run_pixels(input int base, input int n, input int gap_max);
    for (int p = 0; p < n; p++) begin
      int gaps;
      gaps = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      repeat (gaps) cycle(0, DATA_W'($urandom), 0);
      cycle(1, DATA_W'(base + p), 0);
    end
  endtask

  task automatic check_test1(input string tag);
    check_eq({tag, "_count"}, WIN_W'(q_win.size()), WIN_W'(9));
    if (q_win.size() == 9) begin
      check_eq({tag, "_first"}, q_win[0], pack9(1, 2, 3, 6, 7, 8, 11, 12, 13));
      check_eq({tag, "_first_row"}, WIN_W'(q_row[0]), WIN_W'(2));
      check_eq({tag, "_first_col"}, WIN_W'(q_col[0]), WIN_W'(2));
      check_eq({tag, "_last"}, q_win[8], pack9(13, 14, 15, 18, 19, 20, 23, 24, 25));
    end
  endtask

  initial begin
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
    row_length = 8'd5; stride2 = 1'b0;
    model_reset();

    // Reset state
    #7;
    check_eq("rst_valid", WIN_W'(win_valid), '0);
    check_eq("rst_data", win_data, '0);
    check_eq("rst_err", WIN_W'(cfg_err), '0);
    #5 rst = 1'b1;

    // Test 1: 5-pixel rows, pixels 1..25 back-to-back
    restart(5, 0);
    run_pixels(1, 25, 0);
    check_test1("t1");
    t1_win = q_win;

    // Test 2: stride-2 decimation
    restart(5, 1);
    run_pixels(1, 25, 0);
    check_eq("t2_count", WIN_W'(q_win.size()), WIN_W'(4));
    if (q_win.size() == 4) begin
      int er [4];
      int ec [4];
      er = '{2, 2, 4, 4};
      ec = '{2, 4, 2, 4};
      for (int i = 0; i < 4; i++) begin
        check_eq("t2_row", WIN_W'(q_row[i]), WIN_W'(er[i]));
        check_eq("t2_col", WIN_W'(q_col[i]), WIN_W'(ec[i]));
      end
    end

    // Test 3: random gaps up to 4 cycles
    restart(5, 0);
    run_pixels(1, 25, 4);
    check_eq("t3_count", WIN_W'(q_win.size()), WIN_W'(t1_win.size()));
    if (q_win.size() == t1_win.size())
      foreach (q_win[i]) check_eq("t3_seq", q_win[i], t1_win[i]);

    // Test 4: clear together with pixel 8, then frame 101..125
    restart(5, 0);
    run_pixels(1, 7, 0);
    cycle(1, DATA_W'(8), 1);
    clear_capture();
    run_pixels(101, 25, 0);
    check_eq("t4_count", WIN_W'(q_win.size()), WIN_W'(9));
    if (q_win.size() > 0)
      check_eq("t4_first", q_win[0], pack9(101, 102, 103, 106, 107, 108, 111, 112, 113));

    // Test 5: illegal row length, then recovery
    restart(2, 0);
    for (int i = 0; i < 20; i++) cycle(1, DATA_W'($urandom), 0);
    check_eq("t5_err", WIN_W'(cfg_err), WIN_W'(1));
    check_eq("t5_count", WIN_W'(q_win.size()), '0);
    restart(5, 0);
    check_eq("t5_err_clr", WIN_W'(cfg_err), '0);
    run_pixels(1, 25, 0);
    check_test1("t5");

    // Test 6: asynchronous reset mid-row
    restart(5, 0);
    run_pixels(1, 8, 0);
    #3 rst = 1'b0;
    #1;
    check_eq("t6_valid", WIN_W'(win_valid), '0);
    check_eq("t6_data", win_data, '0);
    check_eq("t6_row", WIN_W'(win_row), '0);
    check_eq("t6_col", WIN_W'(win_col), '0);
    check_eq("t6_err", WIN_W'(cfg_err), '0);
    model_reset();
    #12 rst = 1'b1;
    cycle(0, '0, 0);
    clear_capture();
    run_pixels(1, 25, 0);
    check_test1("t6");

    // Random frames: row length, stride, pixel values and gaps all random
    for (int it = 0; it < 6; it++) begin
      int len;
      len = int'($urandom_range(3, 12));
      restart(len, bit'($urandom_range(0, 1)));
      for (int p = 0; p < len * 6; p++) begin
        repeat ($urandom_range(0, 2)) cycle(0, DATA_W'($urandom), 0);
        cycle(1, DATA_W'($urandom), 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
